output_frame_sequencer: RTL and testbench
=========================================

Name: output_frame_sequencer

Overview:
- Sits between the NCO core and the 2-bit split output terminal.
- Buffers 12-bit X/Y sample pairs with their invert-sign flag in a small FIFO.
- Serializes each pair LSB-chunk-first onto the 2-bit lanes using the terminal's single-pulse Rdy/Vld protocol, then time-shares the terminal's 12-bit Dout between X and Y by driving selXY.
- The terminal applies the IS bit it latched in the previous frame, so the sequencer inserts a priming frame whenever the IS value must change.

Parameters:
- DEPTH, 4: sample FIFO entries (power of 2, ≥2).
- HOLD, 4: cycles each of X and Y is shown on Dout (≥1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- s_valid  in  1  sample offered
- s_ready  out  1  FIFO not full
- s_x  in  12  X sample
- s_y  in  12  Y sample
- s_is  in  1  invert-sign request for this sample
- cfg_sign  in  1  1: unsigned (offset-binary) output, 0: signed
- xin  out  2  X lane to terminal
- yin  out  2  Y lane to terminal
- rdy  out  1  frame-start pulse to terminal
- vld  in  1  terminal Vld return
- is_out  out  1  terminal ISin
- sel_xy  out  1  terminal selXY (1 = X)
- sel_sign  out  1  terminal selSign
- disp_valid  out  1  Dout currently carries a real sample
- err  out  1  sticky protocol error

Behaviour:
- All outputs are registered.
- Reset values: s_ready=0 during reset, 1 after; xin=yin=0, rdy=0, is_out=0, sel_xy=1, sel_sign=0, disp_valid=0, err=0. FIFO is emptied. The latched-IS tracker is cleared to "unknown".
- Frame timing, where F is the cycle rdy=1:
  - rdy is exactly one cycle wide.
  - F+1..F+6: xin = x[2k+1:2k] and yin = y[2k+1:2k] for k = 0..5.
  - Outside these cycles, xin = yin = 0.
  - F+7 (LATCH): vld must be 1; is_out carries the frame's IS.
  - From F+8, terminal Dout holds the result.
- sel_sign is loaded from cfg_sign at every F and held until the next F.
- States:
  - IDLE: FIFO empty → stay. FIFO not empty → compare the head's s_is with the latched tracker. Unknown or different → PRIME; equal → LOAD.
  - PRIME: frame with zero data and is_out = head IS. Does not pop the FIFO. After LATCH: tracker = head IS, then go to LOAD at F+8 with no show phase. disp_valid stays 0.
  - LOAD: pops the head at F and runs F..F+6.
  - LATCH: one cycle; then SHOW_X.
  - SHOW_X: HOLD cycles, sel_xy=1, disp_valid=1.
  - SHOW_Y: HOLD cycles, sel_xy=0, disp_valid=1. Exit to IDLE evaluation, so the minimum real-frame period is 8+2·HOLD.
- is_out holds its last value between frames.
- FIFO:
  - Push when s_valid && s_ready; s_ready = !full. No bypass when full, even if a pop occurs in the same cycle.
  - A push into an empty FIFO is visible to IDLE in the next cycle.
  - Simultaneous push and pop when not full: both occur and the count is unchanged.
  - Pointers wrap modulo DEPTH.
- Vld check:
  - err sets if vld=0 in a LATCH cycle, or vld=1 in any other cycle.
  - After reset, a 9-cycle blanking counter suppresses checks, because terminal frames still in flight may return Vld.
  - err clears only on reset.
- Reset mid-frame: returns to IDLE next cycle with all outputs at reset values. The FIFO contents are lost and the tracker becomes unknown.

Decomposition:
- Shared package:
  - state enum (IDLE, PRIME, LOAD, LATCH, SHOW_X, SHOW_Y)
  - CHUNKS = 6, LANE_W = 2, SAMPLE_W = 12, LATCH_OFS = 7
  - packed sample struct {is, x, y}
- One sub-module: sample_fifo (DEPTH × 25 bits, synchronous, full/empty flags).

Test Plan:
1. After reset, push x=0xABC, y=0x123, is=0, cfg_sign=1 (this exercises PRIME then LOAD):
   - PRIME frame: rdy at F, zero lanes, is_out=0 at F+7.
   - Real frame: rdy at F+8; xin chunks 0,3,3,2,2,2; yin chunks 3,0,2,0,1,0; sel_sign=1.
   - SHOW_X for 4 cycles, then SHOW_Y for 4 cycles.
2. Three samples, all is=1, pushed back-to-back → exactly one PRIME; real frames spaced 16 cycles apart; disp_valid high for 8 of every 16 cycles.
3. Samples with is=0,1,0 → PRIME inserted before each of the three real frames; is_out at each real LATCH equals 0,1,0.
4. With DEPTH=4, push 6 samples while the sequencer is busy → s_ready=0 after the 4th accepted push; no sample lost or duplicated; output order matches input order.
5. Tie vld=0 → err=1 after the first LATCH and stays 1. Pulse vld at F+5 → err=1. Pulse vld 3 cycles after reset release → err stays 0.
6. Assert rst_n=0 at F+3 → next cycle all outputs at reset values and the FIFO empty. After release, the next sample is preceded by a PRIME.

Source files
------------

// File: rtl/output_frame_sequencer_pkg.sv
// Shared types and constants for the output frame sequencer and its sample FIFO.
package output_frame_sequencer_pkg;

  localparam int unsigned CHUNKS    = 6;
  localparam int unsigned LANE_W    = 2;
  localparam int unsigned SAMPLE_W  = 12;
  localparam int unsigned LATCH_OFS = 7;

  typedef enum logic [2:0] {StIdle, StPrime, StLoad, StLatch, StShowX, StShowY} state_e;

  typedef struct packed {
    logic                is;
    logic [SAMPLE_W-1:0] x;
    logic [SAMPLE_W-1:0] y;
  } sample_t;

endpackage

// File: rtl/output_frame_sequencer_if.sv
// Sample stream from the NCO core into the output frame sequencer.
interface output_frame_sequencer_if;
  import output_frame_sequencer_pkg::*;

  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_x;
  logic [SAMPLE_W-1:0] s_y;
  logic                s_is;

  modport master (output s_valid, s_x, s_y, s_is, input s_ready);
  modport slave  (input s_valid, s_x, s_y, s_is, output s_ready);

endinterface

// File: rtl/output_frame_sequencer_sample_fifo.sv
// Synchronous sample FIFO; ready is registered and equals !full, so a full FIFO never
// accepts a push even when a pop happens in the same cycle.
module output_frame_sequencer_sample_fifo
  import output_frame_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  sample_t wdata,
  output sample_t rdata,
  output logic    empty,
  output logic    ready
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  sample_t       mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign push_ok = push && ready;
  assign pop_ok  = pop && !empty;
  assign empty   = (cnt_q == '0);
  assign rdata   = mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ready  <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
      ready <= (cnt_d != FullCnt);
    end
  end

endmodule

// File: rtl/output_frame_sequencer.sv
// Serializes buffered X/Y samples onto the 2-bit terminal lanes, inserting priming frames
// whenever the terminal's latched IS must change, then time-shares Dout between X and Y.
module output_frame_sequencer
  import output_frame_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HOLD  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output_frame_sequencer_if.slave  s,
  input  logic                     cfg_sign,
  output logic [LANE_W-1:0]        xin,
  output logic [LANE_W-1:0]        yin,
  output logic                     rdy,
  input  logic                     vld,
  output logic                     is_out,
  output logic                     sel_xy,
  output logic                     sel_sign,
  output logic                     disp_valid,
  output logic                     err
);

  localparam int unsigned CntMax      = (HOLD > LATCH_OFS) ? HOLD : LATCH_OFS;
  localparam int unsigned CntW        = $clog2(CntMax + 1);
  localparam logic [3:0]  BlankCycles = 4'd9;

  state_e              st_q, st_d, start_st;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] xsh_q, xsh_d, ysh_q, ysh_d;
  logic                frame_is_q, frame_is_d, prime_q, prime_d;
  logic                trk_v_q, trk_v_d, trk_q, trk_d;
  logic [3:0]          blank_q, blank_d;
  logic [LANE_W-1:0]   xin_d, yin_d;
  logic                rdy_d, is_out_d, sel_xy_d, sel_sign_d, disp_valid_d, err_d;
  logic                empty, pop, head_prime;
  sample_t             head, wdata;

  assign wdata = '{is: s.s_is, x: s.s_x, y: s.s_y};

  output_frame_sequencer_sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s.s_valid),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .empty (empty),
    .ready (s.s_ready)
  );

  // The terminal applies the IS latched one frame earlier, so an unknown or differing
  // latched value needs a priming frame first.
  assign head_prime = !trk_v_q || (trk_q != head.is);
  assign start_st   = head_prime ? StPrime : StLoad;

  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q + 1'b1;
    xsh_d      = xsh_q;
    ysh_d      = ysh_q;
    frame_is_d = frame_is_q;
    prime_d    = prime_q;
    trk_v_d    = trk_v_q;
    trk_d      = trk_q;
    xin_d      = '0;
    yin_d      = '0;
    is_out_d   = is_out;
    pop        = 1'b0;

    unique case (st_q)
      StIdle: begin
        cnt_d = '0;
        if (!empty) st_d = start_st;
      end
      StPrime, StLoad: begin
        if (cnt_q == '0) frame_is_d = head.is;
        if (st_q == StLoad) begin
          if (cnt_q == '0) begin
            pop   = 1'b1;
            xin_d = head.x[LANE_W-1:0];
            yin_d = head.y[LANE_W-1:0];
            xsh_d = head.x >> LANE_W;
            ysh_d = head.y >> LANE_W;
          end else if (cnt_q < CntW'(CHUNKS)) begin
            xin_d = xsh_q[LANE_W-1:0];
            yin_d = ysh_q[LANE_W-1:0];
            xsh_d = xsh_q >> LANE_W;
            ysh_d = ysh_q >> LANE_W;
          end
        end
        if (cnt_q == CntW'(LATCH_OFS - 1)) begin
          st_d     = StLatch;
          cnt_d    = '0;
          is_out_d = frame_is_q;
        end
      end
      StLatch: begin
        cnt_d   = '0;
        trk_v_d = 1'b1;
        trk_d   = frame_is_q;
        st_d    = prime_q ? StLoad : StShowX;
      end
      StShowX: begin
        if (cnt_q == CntW'(HOLD - 1)) begin
          st_d  = StShowY;
          cnt_d = '0;
        end
      end
      StShowY: begin
        if (cnt_q == CntW'(HOLD - 1)) begin
          cnt_d = '0;
          st_d  = empty ? StIdle : start_st;
        end
      end
      default: begin
        st_d  = StIdle;
        cnt_d = '0;
      end
    endcase

    rdy_d = ((st_d == StPrime) || (st_d == StLoad)) && (st_d != st_q);
    if (rdy_d) prime_d = (st_d == StPrime);
    sel_sign_d   = rdy_d ? cfg_sign : sel_sign;
    sel_xy_d     = (st_d != StShowY);
    disp_valid_d = (st_d == StShowX) || (st_d == StShowY);

    // Vld is expected exactly in LATCH once the post-reset blanking window has expired.
    err_d   = err || ((blank_q == '0) && ((st_q == StLatch) != vld));
    blank_d = (blank_q == '0) ? '0 : blank_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q       <= StIdle;
      cnt_q      <= '0;
      xsh_q      <= '0;
      ysh_q      <= '0;
      frame_is_q <= 1'b0;
      prime_q    <= 1'b0;
      trk_v_q    <= 1'b0;
      trk_q      <= 1'b0;
      blank_q    <= BlankCycles;
      xin        <= '0;
      yin        <= '0;
      rdy        <= 1'b0;
      is_out     <= 1'b0;
      sel_xy     <= 1'b1;
      sel_sign   <= 1'b0;
      disp_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      xsh_q      <= xsh_d;
      ysh_q      <= ysh_d;
      frame_is_q <= frame_is_d;
      prime_q    <= prime_d;
      trk_v_q    <= trk_v_d;
      trk_q      <= trk_d;
      blank_q    <= blank_d;
      xin        <= xin_d;
      yin        <= yin_d;
      rdy        <= rdy_d;
      is_out     <= is_out_d;
      sel_xy     <= sel_xy_d;
      sel_sign   <= sel_sign_d;
      disp_valid <= disp_valid_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_output_frame_sequencer.sv
// Randomized bench for output_frame_sequencer: a terminal model returns Vld, and a frame-level
// reference model predicts priming, lane chunks, IS, show phases and frame start timing.
module tb_output_frame_sequencer;
  import output_frame_sequencer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned HOLD  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_sign = 1'b0;
  logic       vld;
  logic [1:0] xin, yin;
  logic       rdy, is_out, sel_xy, sel_sign, disp_valid, err;

  output_frame_sequencer_if sif ();

  output_frame_sequencer #(
    .DEPTH (DEPTH),
    .HOLD  (HOLD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (sif),
    .cfg_sign   (cfg_sign),
    .xin        (xin),
    .yin        (yin),
    .rdy        (rdy),
    .vld        (vld),
    .is_out     (is_out),
    .sel_xy     (sel_xy),
    .sel_sign   (sel_sign),
    .disp_valid (disp_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model state: accepted samples in order, plus what the terminal has latched.
  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic        is;
    int          stamp;
  } ref_t;
  ref_t samples[$];
  int   rf_q[$];
  bit   trk_known = 0;
  logic trk = 1'b0;
  bit   mon_en = 0;
  bit   mon_busy = 0;
  int   n_prime = 0;
  int   n_real = 0;

  // Terminal model: Vld comes back seven cycles after each rdy pulse.
  int lat_cnt = 0;
  bit vld_tie0 = 0;
  bit vld_force = 0;
  assign vld = ((lat_cnt == 1) && !vld_tie0) || vld_force;
  always @(negedge clk) begin
    if (!rst_n)          lat_cnt <= 0;
    else if (rdy)        lat_cnt <= 8;
    else if (lat_cnt > 0) lat_cnt <= lat_cnt - 1;
  end

  task automatic do_frame();
    bit   again;
    bit   prime;
    ref_t h;
    int   fcyc;
    mon_busy = 1;
    do begin
      again = 0;
      fcyc  = cyc;
      if (samples.size() == 0) begin
        check_val("rdy_spurious", 32'(rdy), 32'd0);
      end else begin
        h     = samples[0];
        prime = !trk_known || (trk !== h.is);
        check_val("rdy_early", 32'(h.stamp + 2 <= cyc), 32'd1);
        check_val("sel_sign", 32'(sel_sign), 32'(cfg_sign));
        for (int k = 0; k < CHUNKS; k++) begin
          @(negedge clk);
          if (prime) check_val("prime_lanes", {rdy, disp_valid, xin, yin}, 32'd0);
          else check_val("real_lanes", {rdy, disp_valid, xin, yin},
                         {2'b00, h.x[2*k +: 2], h.y[2*k +: 2]});
        end
        @(negedge clk);
        check_val("latch", {rdy, disp_valid, xin, yin, is_out}, {6'b0, h.is});
        trk_known = 1;
        trk       = h.is;
        if (prime) begin
          n_prime++;
          @(negedge clk);
          check_val("prime_to_load", 32'(rdy), 32'd1);
          again = rdy;
        end else begin
          void'(samples.pop_front());
          n_real++;
          rf_q.push_back(fcyc);
          for (int j = 0; j < 2 * HOLD; j++) begin
            @(negedge clk);
            check_val("show", {rdy, disp_valid, sel_xy, xin, yin},
                      {1'b0, 1'b1, (j < HOLD) ? 1'b1 : 1'b0, 4'b0});
          end
        end
      end
    end while (again);
    mon_busy = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        if (rdy) begin
          do_frame();
        end else begin
          check_val("idle_out", {disp_valid, sel_xy, xin, yin}, {1'b0, 1'b1, 4'b0});
          if (samples.size() > 0 && samples[0].stamp + 2 <= cyc)
            check_val("frame_late", 32'(rdy), 32'd1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_sample(input logic [11:0] x, input logic [11:0] y, input logic is);
    int n = 0;
    sif.s_valid = 1'b1;
    sif.s_x     = x;
    sif.s_y     = y;
    sif.s_is    = is;
    while (!sif.s_ready && n < 300) begin
      tick(1);
      n++;
    end
    if (!sif.s_ready) check_val("push_timeout", 32'd0, 32'd1);
    else samples.push_back('{x: x, y: y, is: is, stamp: cyc});
    tick(1);
    sif.s_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((samples.size() > 0 || mon_busy) && n < 3000) begin
      tick(1);
      n++;
    end
    if (n >= 3000) check_val("drain_timeout", 32'd0, 32'd1);
    tick(2);
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!rdy && n < 60) begin
      tick(1);
      n++;
    end
    if (!rdy) check_val("rdy_timeout", 32'd0, 32'd1);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick(3);
    samples.delete();
    trk_known = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    logic r;
    sif.s_valid = 1'b0;
    sif.s_x     = '0;
    sif.s_y     = '0;
    sif.s_is    = 1'b0;

    // Reset values, s_ready low during reset and high afterwards.
    rst_n = 1'b0;
    tick(2);
    check_val("rst_outputs", {sif.s_ready, xin, yin, rdy, is_out, sel_xy, sel_sign, disp_valid, err},
              {1'b0, 2'b0, 2'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    reset_dut();
    tick(1);
    check_val("ready_after_rst", 32'(sif.s_ready), 32'd1);
    mon_en = 1;

    // 1: single sample from unknown tracker -> PRIME then LOAD.
    cfg_sign = 1'b1;
    push_sample(12'hABC, 12'h123, 1'b0);
    drain();
    check_val("t1_primes", n_prime, 1);
    check_val("t1_reals", n_real, 1);
    check_val("t1_err", 32'(err), 32'd0);

    // 2: three back-to-back is=1 samples -> one PRIME, real frames 16 cycles apart.
    cfg_sign = 1'b0;
    p0 = n_prime;
    rf_q.delete();
    for (int i = 0; i < 3; i++) push_sample(12'($urandom), 12'($urandom), 1'b1);
    drain();
    check_val("t2_primes", n_prime - p0, 1);
    check_val("t2_frames", rf_q.size(), 3);
    for (int i = 1; i < rf_q.size(); i++)
      check_val("t2_period", rf_q[i] - rf_q[i-1], 8 + 2 * HOLD);

    // 3: alternating IS -> a PRIME before every real frame.
    p0 = n_prime;
    push_sample(12'($urandom), 12'($urandom), 1'b0);
    push_sample(12'($urandom), 12'($urandom), 1'b1);
    push_sample(12'($urandom), 12'($urandom), 1'b0);
    drain();
    check_val("t3_primes", n_prime - p0, 3);

    // 4: overfill while busy; s_ready drops after the fourth accepted push.
    r = 1'($urandom);
    push_sample(12'($urandom), 12'($urandom), r);
    drain();
    push_sample(12'($urandom), 12'($urandom), r);
    for (int i = 0; i < 4; i++) push_sample(12'($urandom), 12'($urandom), 1'($urandom));
    check_val("t4_full", 32'(sif.s_ready), 32'd0);
    for (int i = 0; i < 2; i++) push_sample(12'($urandom), 12'($urandom), 1'($urandom));
    drain();

    // Random traffic with random gaps and IS patterns.
    for (int b = 0; b < 3; b++) begin
      cfg_sign = 1'($urandom);
      for (int i = 0; i < 8; i++) begin
        push_sample(12'($urandom), 12'($urandom), ($urandom_range(0, 3) == 0) ? ~r : r);
        if ($urandom_range(0, 2) == 0) r = ~r;
        tick($urandom_range(0, 20));
      end
      drain();
    end
    check_val("rand_err", 32'(err), 32'd0);

    // 5a: Vld never returned -> sticky err.
    reset_dut();
    vld_tie0 = 1;
    tick(10);
    push_sample(12'($urandom), 12'($urandom), 1'b1);
    drain();
    check_val("t5_tie0_err", 32'(err), 32'd1);
    tick(5);
    check_val("t5_tie0_sticky", 32'(err), 32'd1);
    vld_tie0 = 0;

    // 5b: stray Vld at F+5 -> err.
    reset_dut();
    tick(10);
    check_val("t5_clear", 32'(err), 32'd0);
    push_sample(12'($urandom), 12'($urandom), 1'b0);
    wait_rdy();
    tick(5);
    vld_force = 1;
    tick(1);
    vld_force = 0;
    tick(1);
    check_val("t5_stray_err", 32'(err), 32'd1);
    drain();

    // 5c: Vld inside the post-reset blanking window is ignored.
    reset_dut();
    tick(3);
    vld_force = 1;
    tick(1);
    vld_force = 0;
    tick(20);
    check_val("t5_blank", 32'(err), 32'd0);

    // 6: reset at F+3 aborts the frame and empties the FIFO.
    tick(5);
    mon_en = 0;
    push_sample(12'($urandom), 12'($urandom), 1'b1);
    wait_rdy();
    tick(3);
    rst_n = 1'b0;
    tick(1);
    check_val("t6_rst_outputs",
              {sif.s_ready, xin, yin, rdy, is_out, sel_xy, sel_sign, disp_valid, err},
              {1'b0, 2'b0, 2'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;
    samples.delete();
    trk_known = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check_val("t6_fifo_empty", {rdy, disp_valid}, 32'd0);
    end
    mon_en = 1;
    p0 = n_prime;
    push_sample(12'($urandom), 12'($urandom), 1'b0);
    drain();
    check_val("t6_prime", n_prime - p0, 1);
    check_val("t6_err", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
